dynamic_branch_predictor: RTL

//  Parametrised direct-mapped BTB with N-bit saturating direction counters.

---
 rtl/cpu_types_pkg.sv | 9 +
 rtl/sat_counter.sv | 10 +
 rtl/dynamic_branch_predictor.sv | 80 ++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types and branch predictor constants.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    localparam word_t PC_STEP = 32'd4;
    // weakly-taken counter start value for a CTR_BITS-wide counter
    function automatic logic [3:0] BP_CTR_INIT(input int bits);
        return 4'(1 << (bits - 1));
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: next value of a W-bit up/down counter that saturates at both ends.
module sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] ctr,
    input  logic         up,
    output logic [W-1:0] nxt
);
    assign nxt = up ? (&ctr ? ctr : ctr + 1'b1) : (|ctr ? ctr - 1'b1 : ctr);
endmodule

// File: rtl/dynamic_branch_predictor.sv
// dynamic_branch_predictor: direct-mapped BTB with saturating direction counters,
// zero-latency lookup at fetch, update and mispredict detection at resolve.
module dynamic_branch_predictor
    import cpu_types_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int BYPASS   = 0,
    parameter int STAT_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              inv_all,
    input  word_t             if_pc,
    output logic              pred_taken,
    output word_t             pred_target,
    input  logic              upd_valid,
    input  word_t             upd_pc,
    input  logic              upd_taken,
    input  word_t             upd_target,
    input  logic              upd_pred_taken,
    input  word_t             upd_pred_target,
    output logic              mispredict,
    output word_t             correct_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;
    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        word_t               target;
        logic [CTR_BITS-1:0] ctr;
    } entry_t;
    entry_t              tbl [ENTRIES];
    entry_t              upd_old, upd_new, look;
    logic [IDX_W-1:0]    upd_idx, if_idx;
    logic [TAG_W-1:0]    upd_tag, if_tag;
    logic [CTR_BITS-1:0] ctr_nxt;
    logic                upd_hit, do_write, do_count;
    logic                unused_lsb;
    assign unused_lsb = ^{if_pc[1:0], upd_pc[1:0]};
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];
    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[31:IDX_W+2];
    assign upd_old = tbl[upd_idx];
    assign upd_hit = upd_old.valid && upd_old.tag == upd_tag;
    sat_counter #(.W(CTR_BITS)) u_ctr (.ctr(upd_old.ctr), .up(upd_taken), .nxt(ctr_nxt));
    // a miss only allocates on taken; a hit keeps its old target when not taken
    assign upd_new = upd_hit
        ? entry_t'{valid: 1'b1, tag: upd_tag, target: upd_taken ? upd_target : upd_old.target, ctr: ctr_nxt}
        : entry_t'{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: CTR_BITS'(BP_CTR_INIT(CTR_BITS))};
    assign do_write = !RST && upd_valid && !stall && !inv_all && (upd_hit || upd_taken);
    assign do_count = upd_valid && !stall;
    assign look = (BYPASS != 0 && do_write && upd_idx == if_idx) ? upd_new : tbl[if_idx];
    // RST masks the lookup so outputs reflect the cleared table during reset
    assign pred_taken  = !RST && look.valid && look.tag == if_tag && look.ctr[CTR_BITS-1];
    assign pred_target = pred_taken ? look.target : if_pc + PC_STEP;
    assign mispredict  = upd_valid && (upd_pred_taken != upd_taken ||
                                       (upd_taken && upd_pred_target != upd_target));
    assign correct_pc  = upd_taken ? upd_target : upd_pc + PC_STEP;
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (inv_all) begin
                for (int i = 0; i < ENTRIES; i++) tbl[i].valid <= 1'b0;
            end else if (do_write) begin
                tbl[upd_idx] <= upd_new;
            end
            if (do_count && !(&stat_branches)) stat_branches <= stat_branches + 1'b1;
            if (do_count && mispredict && !(&stat_mispred)) stat_mispred <= stat_mispred + 1'b1;
        end
    end
endmodule
